rf_access_sequencer: RTL
========================

# rf_access_sequencer

Initiator-side controller for the 16×32 register bank: it accepts one instruction-level request (two source registers, one destination), drives the bank read ports, captures the registered read data, and hands the operands to the ALU over a valid/ready handshake. It then waits for the result and performs the write-back cycle with the bank's active-low write enable. It sits between the calculator's instruction decoder and the register bank/ALU pair, and is the only master of the bank ports.

## Interface
- DATA_W, 32, operand/result width
- ADDR_W, 4, register address width (16 registers)
- TIMEOUT, 255, max cycles waited for `res_valid` before abort (8-bit counter)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_rn, req_rm, req_rd  in  ADDR_W  source A, source B, destination
- req_wb  in  1  1 = write result back, 0 = discard (compare-type ops)
- rf_a1, rf_a2  out  ADDR_W  bank read addresses
- rf_rd1, rf_rd2  in  DATA_W  bank read data, registered by bank one cycle after address
- rf_a3  out  ADDR_W  bank write address
- rf_wd3  out  DATA_W  bank write data
- rf_we3  out  1  bank write enable, ACTIVE LOW; bank writes on falling edge of clk
- op_valid  out  1  operands valid to ALU
- op_ready  in  1  ALU accepts operands
- op_a, op_b  out  DATA_W  operands
- res_valid  in  1  ALU result valid (may be same cycle as op_ready)
- res_data  in  DATA_W  ALU result
- done  out  1  one-cycle pulse, request retired (written or discarded)
- err  out  1  one-cycle pulse, timeout abort

## Operation
- States: IDLE, READ, LATCH, EXEC, RESULT, WRITE.
- IDLE: req_ready=1. On req_valid: latch rn/rm/rd/wb, go READ.
- READ: rf_a1=rn, rf_a2=rm (held stable until next request). Always 1 cycle -> LATCH.
- LATCH: rf_rd1/rf_rd2 valid; capture into op_a/op_b at end of cycle -> EXEC.
- EXEC: op_valid=1, op_a/op_b held. On op_ready: if res_valid same cycle, capture res_data and go WRITE (wb=1) or IDLE with done (wb=0); else -> RESULT, clear timeout counter.
- RESULT: op_valid=0. On res_valid: capture res_data; wb=1 -> WRITE, wb=0 -> IDLE with done. Counter increments each cycle without res_valid; at TIMEOUT -> IDLE with err, no write, no done.
- WRITE: rf_a3=rd, rf_wd3=result, rf_we3=0 for exactly one cycle; -> IDLE, done pulses on the IDLE-entry edge.
- res_valid outside EXEC/RESULT is ignored. req_valid outside IDLE is ignored (not queued).
- Destination equal to a source is legal; the write follows the read, so no hazard.
- Reset values: state IDLE, req_ready=1, rf_we3=1, all addresses/data/op_a/op_b/op_valid/done/err/counter = 0.
- Reset asserted mid-operation: rf_we3 goes to 1 asynchronously, so no write occurs even on the pending falling edge; request is dropped.

## Timing
- Request accepted on edge 0; addresses valid in cycle 1; bank data valid in cycle 2; op_valid first high in cycle 3.
- Minimum latency to done, with op_ready and res_valid both high in cycle 3: rf_we3 low in cycle 4, done high in cycle 5, next request accepted at end of cycle 5.
- rf_a3/rf_wd3 are registered and stable for the whole WRITE cycle, covering the bank's mid-cycle falling-edge write.
- Back-to-back read-after-write: a next request's READ happens no earlier than the cycle after WRITE, so the bank returns the new value.
- op_valid, once raised, stays high with stable operands until op_ready.

## Structure
- Shared package `calc_pkg`: state enum, DATA_W/ADDR_W constants, `RF_WE_ACTIVE = 1'b0`.
- Single module; the timeout counter stays inline. No sub-module is needed.

## Test plan
- Bank preloaded R1=5, R2=7; request rn=1, rm=2, rd=3, wb=1; ALU model returns a+b with zero delay -> op_a=5, op_b=7, rf_we3 low exactly one cycle with a3=3, wd3=12, done in cycle 5, bank R3=12.
- Same request with wb=0 -> done pulses, rf_we3 never low, R3 unchanged.
- ALU op_ready delayed 3 cycles, res_valid 4 cycles after that -> op_valid held with stable operands throughout; write-back of the correct value; req_valid pulsed mid-flight is ignored.
- res_valid never asserted -> err pulses after 255 RESULT cycles, no write, req_ready returns to 1.
- Back-to-back: write R4=0xDEADBEEF, then request rn=4 -> op_a=0xDEADBEEF.
- rst_n asserted during the WRITE cycle before the falling edge -> rf_we3=1 immediately, bank unchanged, state IDLE.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: sequencer states, bus widths
// and the register bank write-enable polarity.
package calc_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam logic RF_WE_ACTIVE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_EXEC,
    S_RESULT,
    S_WRITE
  } state_t;
endpackage

// File: rtl/rf_access_sequencer.sv
// Sole master of the register bank ports: reads two sources, hands them to the
// ALU over valid/ready, waits (bounded) for the result and writes it back.
module rf_access_sequencer #(
  parameter int DATA_W  = calc_pkg::DATA_W,
  parameter int ADDR_W  = calc_pkg::ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rn,
  input  logic [ADDR_W-1:0] req_rm,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wb,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we3,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              done,
  output logic              err
);
  import calc_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rn_q, rm_q, rd_q;
  logic              wb_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, res_q;
  logic [7:0]        cnt;
  logic              done_q, err_q;

  logic take_req, cap_ops, cap_res, cnt_clr, cnt_inc, done_nxt, err_nxt;

  always_comb begin
    state_nxt = state;
    take_req  = 1'b0;
    cap_ops   = 1'b0;
    cap_res   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          take_req  = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_LATCH;
      S_LATCH: begin
        cap_ops   = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (op_ready) begin
          if (res_valid) begin
            cap_res   = 1'b1;
            state_nxt = wb_q ? S_WRITE : S_IDLE;
            done_nxt  = ~wb_q;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (res_valid) begin
          cap_res   = 1'b1;
          state_nxt = wb_q ? S_WRITE : S_IDLE;
          done_nxt  = ~wb_q;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          // Abort: drop the result, no write-back and no done.
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WRITE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rn_q   <= '0;
      rm_q   <= '0;
      rd_q   <= '0;
      wb_q   <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      if (take_req) begin
        rn_q <= req_rn;
        rm_q <= req_rm;
        rd_q <= req_rd;
        wb_q <= req_wb;
      end
      if (cap_ops) begin
        op_a_q <= rf_rd1;
        op_b_q <= rf_rd2;
      end
      if (cap_res) res_q <= res_data;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 8'd1;
    end
  end

  // Write enable decodes straight from state so an async reset deasserts it
  // before the bank's falling-edge write.
  assign rf_we3    = (state == S_WRITE) ? RF_WE_ACTIVE : ~RF_WE_ACTIVE;
  assign req_ready = (state == S_IDLE);
  assign op_valid  = (state == S_EXEC);
  assign rf_a1     = rn_q;
  assign rf_a2     = rm_q;
  assign rf_a3     = rd_q;
  assign rf_wd3    = res_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule
